// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: round-robin sharing of one external signed adder among
// N_REQ requesters. The winner's operands are driven to the adder in the same
// cycle, and the sum is captured with the winner's ID in a one-entry output
// register that has a valid/ready handshake.
module add_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 19,
    parameter bit SAT   = 1'b0,
    localparam int RW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DW-1:0]   req_data1,
    input  logic [N_REQ*DW-1:0]   req_data2,
    output logic [DW-1:0]         add_data1,
    output logic [DW-1:0]         add_data2,
    input  logic [DW-1:0]         add_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DW-1:0]         res_data,
    output logic [RW-1:0]         res_id,
    output logic                  res_ovf
);

    // Largest and smallest representable signed DW-bit values.
    localparam logic [DW-1:0] SUM_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SUM_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [RW-1:0] ptr_q, ptr_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [RW-1:0] res_id_q, res_id_d;
    logic          res_ovf_q, res_ovf_d;

    logic [RW-1:0] gnt_s;
    logic          any_s;
    logic          can_acc_s;
    logic          xfer_s;
    logic          ovf_s;

    // Requester index 'off' positions after 'base', wrapping at N_REQ.
    function automatic logic [RW-1:0] rot_idx(input logic [RW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        s = (s >= N_REQ) ? (s - N_REQ) : s;
        return RW'(s);
    endfunction

    // Value to store for a sum: clamped on overflow when saturation is on.
    // 'neg' is the shared sign of the operands (only meaningful on overflow).
    function automatic logic [DW-1:0] fix_sum(input logic [DW-1:0] sum,
                                              input logic ovf, input logic neg);
        logic [DW-1:0] r;
        if (SAT && ovf) begin
            r = neg ? SUM_MIN : SUM_MAX;
        end else begin
            r = sum;
        end
        return r;
    endfunction

    // Round-robin search: the closest valid requester at or after ptr wins.
    always_comb begin
        gnt_s = ptr_q;
        any_s = 1'b0;
        // Walk from the farthest offset down so the nearest hit is kept last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            gnt_s = req_valid[rot_idx(ptr_q, k)] ? rot_idx(ptr_q, k) : gnt_s;
            any_s = any_s | req_valid[rot_idx(ptr_q, k)];
        end
    end

    // Handshake outputs and shared-adder operand drive.
    always_comb begin
        can_acc_s = !res_valid_q || res_ready;
        xfer_s    = can_acc_s && any_s && !rst;
        req_ready = '0;
        add_data1 = {DW{1'b0}};
        add_data2 = {DW{1'b0}};
        if (xfer_s) begin
            req_ready[gnt_s] = 1'b1;
            add_data1        = req_data1[int'(gnt_s)*DW +: DW];
            add_data2        = req_data2[int'(gnt_s)*DW +: DW];
        end else begin
            req_ready = '0;
        end
        // Signed overflow: operands agree in sign but the sum does not.
        ovf_s = (add_data1[DW-1] == add_data2[DW-1]) &&
                (add_result[DW-1] != add_data1[DW-1]);
    end

    // Next state for the output stage and the round-robin pointer.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_ovf_d   = res_ovf_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            res_valid_d = 1'b1;
            res_data_d  = fix_sum(add_result, ovf_s, add_data1[DW-1]);
            res_id_d    = gnt_s;
            res_ovf_d   = ovf_s;
            ptr_d       = rot_idx(gnt_s, 1);
        end else if (res_valid_q && res_ready) begin
            // Drained with nothing new: data fields keep their last value.
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers with synchronous reset; a pending result is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= {RW{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {DW{1'b0}};
            res_id_q    <= {RW{1'b0}};
            res_ovf_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Testbench for add_rr_arbiter: a wrapping instance and a saturating instance
// share the same stimulus, each with its own adder, and are compared against
// an arithmetic reference model of the arbitration and result rules.
module tb_add_rr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 19;
    localparam int MAXV = 262143;
    localparam int MINV = -262144;
    localparam int SPAN = 524288;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data1, req_data2;
    logic            res_ready;

    logic [N-1:0]  rdy0, rdy1;
    logic [DW-1:0] a1_0, a2_0, sum0, rd0;
    logic [DW-1:0] a1_1, a2_1, sum1, rd1;
    logic          rv0, rv1, ovf0, ovf1;
    logic [1:0]    rid0, rid1;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_ptr, m_wrap, m_sat, m_id;
    bit m_vld, m_ovf;

    always #5 clk = ~clk;

    // External shared adders (native wrap-around).
    assign sum0 = a1_0 + a2_0;
    assign sum1 = a1_1 + a2_1;

    add_rr_arbiter #(.N_REQ(N), .DW(DW), .SAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_data1(req_data1), .req_data2(req_data2),
        .add_data1(a1_0), .add_data2(a2_0), .add_result(sum0),
        .res_valid(rv0), .res_ready(res_ready), .res_data(rd0),
        .res_id(rid0), .res_ovf(ovf0));

    add_rr_arbiter #(.N_REQ(N), .DW(DW), .SAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_data1(req_data1), .req_data2(req_data2),
        .add_data1(a1_1), .add_data2(a2_1), .add_result(sum1),
        .res_valid(rv1), .res_ready(res_ready), .res_data(rd1),
        .res_id(rid1), .res_ovf(ovf1));

    function automatic int get_op(input logic [N*DW-1:0] bus, input int i);
        logic signed [DW-1:0] t;
        t = bus[i*DW +: DW];
        return int'(t);
    endfunction

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit m_xfer();
        return !rst && (!m_vld || res_ready) && (m_grant() >= 0);
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_xfer()) r[m_grant()] = 1'b1;
        return r;
    endfunction

    function automatic int rnd_op();
        logic signed [DW-1:0] t;
        case ($urandom_range(0, 3))
            0: return MAXV - int'($urandom_range(0, 3));
            1: return MINV + int'($urandom_range(0, 3));
            default: begin
                t = DW'($urandom);
                return int'(t);
            end
        endcase
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_data1[i*DW +: DW] = DW'(a);
        req_data2[i*DW +: DW] = DW'(b);
    endtask

    // Advance the model by one clock using the current inputs, then clock.
    task automatic tick();
        int g, a, b, s;
        if (rst) begin
            m_ptr = 0; m_vld = 1'b0; m_wrap = 0; m_sat = 0; m_id = 0; m_ovf = 1'b0;
        end else if (m_xfer()) begin
            g = m_grant();
            a = get_op(req_data1, g);
            b = get_op(req_data2, g);
            s = a + b;
            m_ovf  = (s > MAXV) || (s < MINV);
            m_wrap = (s > MAXV) ? s - SPAN : ((s < MINV) ? s + SPAN : s);
            m_sat  = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
            m_id   = g;
            m_vld  = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (m_vld && res_ready) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 10 * i, i);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (rdy0 !== 4'b0000 || rdy1 !== 4'b0000) begin
                errors++; $display("FAIL reset_ready got %b/%b exp 0000", rdy0, rdy1);
            end
            tick();
        end
        checks++;
        if (rv0 !== 1'b0 || rd0 !== 19'd0 || rid0 !== 2'd0 || ovf0 !== 1'b0 || rv1 !== 1'b0) begin
            errors++; $display("FAIL reset_regs got v=%b d=%h id=%0d o=%b exp zeros", rv0, rd0, rid0, ovf0);
        end
        rst = 1'b0; res_ready = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 4'b0001 || rdy0 !== m_ready()) begin
            errors++; $display("FAIL first_grant got %b exp 0001", rdy0);
        end
        tick();
        checks++;
        if (rv0 !== 1'b1 || rid0 !== 2'd0 || rd0 !== DW'(m_wrap)) begin
            errors++; $display("FAIL first_result got v=%b id=%0d d=%h exp v=1 id=0 d=%h", rv0, rid0, rd0, DW'(m_wrap));
        end
    endtask

    task automatic test_single_add();
        req_valid = 4'b0010; res_ready = 1'b1;
        set_op(1, 100, -30);
        #1;
        checks++;
        if (rdy0 !== 4'b0010 || a1_0 !== 19'd100 || a2_0 !== DW'(-30)) begin
            errors++; $display("FAIL single_drive got rdy=%b a1=%0d a2=%h exp 0010 100 -30", rdy0, a1_0, a2_0);
        end
        tick();
        checks++;
        if (rv0 !== 1'b1 || rd0 !== 19'd70 || rid0 !== 2'd1 || ovf0 !== 1'b0 || rd1 !== 19'd70) begin
            errors++; $display("FAIL single_result got v=%b d=%0d id=%0d o=%b exp 1 70 1 0", rv0, rd0, rid0, ovf0);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int exp_id [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = 4'b0000; tick();
        rst = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 1000 * (i + 1), -i);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rdy0 !== exp_r[c]) begin
                errors++; $display("FAIL rotation_ready[%0d] got %b exp %b", c, rdy0, exp_r[c]);
            end
            tick();
            checks++;
            if (rv0 !== 1'b1 || rid0 !== 2'(exp_id[c]) || rd0 !== DW'(m_wrap)) begin
                errors++; $display("FAIL rotation_result[%0d] got v=%b id=%0d d=%h exp 1 %0d %h", c, rv0, rid0, rd0, exp_id[c], DW'(m_wrap));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sd;
        logic [1:0]    sid;
        logic          so;
        logic [N-1:0]  exp_r [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        sd = rd0; sid = rid0; so = ovf0;
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rdy0 !== 4'b0000 || a1_0 !== 19'd0) begin
                errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", c, rdy0);
            end
            tick();
            checks++;
            if (rv0 !== 1'b1 || rd0 !== sd || rid0 !== sid || ovf0 !== so) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d exp 1 %h %0d", c, rv0, rd0, rid0, sd, sid);
            end
        end
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (rdy0 !== exp_r[c] || rdy0 !== m_ready()) begin
                errors++; $display("FAIL bp_resume[%0d] got %b exp %b", c, rdy0, exp_r[c]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        req_valid = 4'b0100; res_ready = 1'b1;
        set_op(2, MAXV, 1);
        tick();
        checks++;
        if (rd0 !== 19'h40000 || ovf0 !== 1'b1 || rd1 !== 19'h3FFFF || ovf1 !== 1'b1) begin
            errors++; $display("FAIL ovf_pos got wrap=%h/%b sat=%h/%b exp 40000/1 3ffff/1", rd0, ovf0, rd1, ovf1);
        end
        set_op(2, MINV, -1);
        tick();
        checks++;
        if (rd0 !== 19'h3FFFF || ovf0 !== 1'b1 || rd1 !== 19'h40000 || ovf1 !== 1'b1) begin
            errors++; $display("FAIL ovf_neg got wrap=%h/%b sat=%h/%b exp 3ffff/1 40000/1", rd0, ovf0, rd1, ovf1);
        end
        set_op(2, MINV, MAXV);
        tick();
        checks++;
        if (rd0 !== 19'h7FFFF || ovf0 !== 1'b0 || rd1 !== 19'h7FFFF || ovf1 !== 1'b0) begin
            errors++; $display("FAIL ovf_none got wrap=%h/%b sat=%h/%b exp 7ffff/0", rd0, ovf0, rd1, ovf1);
        end
    endtask

    task automatic test_ptr_skip_reset();
        rst = 1'b1; req_valid = 4'b0000; tick();
        rst = 1'b0; req_valid = 4'b0010; res_ready = 1'b1;
        tick();
        req_valid = 4'b1001;
        set_op(0, 5, 6); set_op(3, -7, 2);
        #1;
        checks++;
        if (rdy0 !== 4'b1000) begin
            errors++; $display("FAIL skip_grant3 got %b exp 1000", rdy0);
        end
        tick();
        checks++;
        if (rid0 !== 2'd3 || rd0 !== DW'(-5)) begin
            errors++; $display("FAIL skip_result3 got id=%0d d=%h exp 3 %h", rid0, rd0, DW'(-5));
        end
        req_valid = 4'b0001;
        #1;
        checks++;
        if (rdy0 !== 4'b0001) begin
            errors++; $display("FAIL skip_grant0 got %b exp 0001", rdy0);
        end
        tick();
        checks++;
        if (rid0 !== 2'd0 || rd0 !== 19'd11 || rv0 !== 1'b1) begin
            errors++; $display("FAIL skip_result0 got id=%0d d=%0d v=%b exp 0 11 1", rid0, rd0, rv0);
        end
        req_valid = 4'b0000; res_ready = 1'b0; rst = 1'b1;
        tick();
        checks++;
        if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
            errors++; $display("FAIL midreset_valid got %b/%b exp 0", rv0, rv1);
        end
        rst = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 4'b0001) begin
            errors++; $display("FAIL midreset_ptr got %b exp 0001", rdy0);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] last_rdy, exp_r;
        int g;
        rst = 1'b1; req_valid = 4'b0000; tick();
        rst = 1'b0;
        last_rdy = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_rdy[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_op(i, rnd_op(), rnd_op());
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            exp_r = m_ready();
            g = m_grant();
            checks++;
            if (rdy0 !== exp_r || rdy1 !== exp_r) begin
                errors++; $display("FAIL rand_ready[%0d] got %b/%b exp %b", c, rdy0, rdy1, exp_r);
            end
            checks++;
            if (m_xfer() ? (a1_0 !== DW'(get_op(req_data1, g)) || a2_0 !== DW'(get_op(req_data2, g)))
                         : (a1_0 !== 19'd0 || a2_0 !== 19'd0)) begin
                errors++; $display("FAIL rand_operands[%0d] got %h %h", c, a1_0, a2_0);
            end
            last_rdy = exp_r;
            tick();
            checks++;
            if (rv0 !== m_vld || rv1 !== m_vld || rd0 !== DW'(m_wrap) || rd1 !== DW'(m_sat) ||
                rid0 !== 2'(m_id) || ovf0 !== m_ovf || ovf1 !== m_ovf) begin
                errors++;
                $display("FAIL rand_result[%0d] got v=%b d=%h/%h id=%0d o=%b exp v=%b d=%h/%h id=%0d o=%b",
                         c, rv0, rd0, rd1, rid0, ovf0, m_vld, DW'(m_wrap), DW'(m_sat), m_id, m_ovf);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        req_data1 = '0; req_data2 = '0;
        test_reset();
        test_single_add();
        test_rotation();
        test_backpressure();
        test_overflow();
        test_ptr_skip_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_rr_arbiter.md
Name: add_rr_arbiter

Overview:
Round-robin arbiter that shares one external signed fixed-point adder instance among N_REQ requesters. Each requester presents an operand pair through a valid/ready handshake. The block selects one requester per cycle, drives the shared adder operands, and registers the sum with the requester ID into a one-entry output stage with its own valid/ready handshake. It sits between the datapath stages that need additions and the single adder, so multiple producers can time-share one adder.

Parameters:
N_REQ, 4, number of requesters (2..8); ID width is RW = clog2(N_REQ).
DW, 19, operand/result width, signed two's complement.
SAT, 0, 0 = wrap-around result (native adder behaviour); 1 = clamp to signed DW-bit range on overflow.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  N_REQ  requester i has an operand pair pending.
req_ready  out  N_REQ  one-hot or zero; bit i high = requester i's pair is consumed this cycle.
req_data1  in  N_REQ*DW  packed operand 1; requester i occupies [i*DW +: DW].
req_data2  in  N_REQ*DW  packed operand 2; same packing.
add_data1  out  DW  operand 1 to the shared adder (combinational).
add_data2  out  DW  operand 2 to the shared adder (combinational).
add_result  in  DW  sum returned combinationally by the shared adder.
res_valid  out  1  output register holds a valid result.
res_ready  in  1  downstream accepts the result.
res_data  out  DW  registered result.
res_id  out  RW  index of the requester that produced res_data.
res_ovf  out  1  signed overflow occurred for res_data (independent of SAT).

Behaviour:
- Clock/reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values: res_valid=0, res_data=0, res_id=0, res_ovf=0, round-robin pointer ptr=0. req_ready=0 while rst=1. A result pending at reset is discarded.
- Accept condition: can_acc = !res_valid || res_ready.
- Arbitration: combinational search starting at ptr, then ptr+1 … ptr+N_REQ-1 (mod N_REQ). The first i with req_valid[i]=1 is gnt.
- If can_acc and any req_valid is high: req_ready[gnt]=1, all other bits are 0. This is a transfer.
- Otherwise req_ready is all zero.
- req_ready depends combinationally on req_valid. Requesters must not derive valid from ready.
- Requester rule: once req_valid[i] is raised, it and that requester's operands stay stable until req_ready[i]=1.
- Pointer update: on a transfer, ptr <= (gnt+1) mod N_REQ. With no transfer, ptr holds. Starvation bound: N_REQ-1 transfers.
- Adder drive: on a transfer, add_data1/add_data2 = granted requester's operands. With no transfer, both are 0.
- Latency: 1 cycle. On a transfer at edge k, res_valid=1 after edge k, with res_id=gnt.
- Overflow: ovf = (add_data1[DW-1]==add_data2[DW-1]) && (add_result[DW-1]!=add_data1[DW-1]).
  - res_ovf <= ovf.
  - SAT=0: res_data <= add_result.
  - SAT=1 and ovf: res_data <= 2^(DW-1)-1 if operands are positive, else -2^(DW-1).
- Hold: while res_valid && !res_ready, res_data/res_id/res_ovf are stable, no transfer occurs, and ptr holds.
- Output drain: res_valid && res_ready with no transfer → res_valid <= 0. Data fields keep their last value.
- Simultaneous drain and accept: res_valid && res_ready with a transfer → new result loaded and res_valid stays 1. Sustained throughput is 1 result/cycle with no bubbles.
- Single requester: repeated grants to the same requester are allowed on consecutive cycles.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=4'b1111 → req_ready=0, res_valid=0, res_data=0, res_id=0. First grant after release goes to requester 0.
- Single add: req_valid=4'b0010, data1=100, data2=-30 → req_ready=4'b0010 in the same cycle. Next cycle: res_valid=1, res_data=70, res_id=1, res_ovf=0.
- Full rotation: all 4 requesters valid continuously, res_ready=1 → req_ready sequence 0001, 0010, 0100, 1000, 0001. res_id sequence 0,1,2,3,0 one cycle later, with res_valid held high and no bubbles.
- Backpressure: res_valid=1, res_ready=0 for 3 cycles, all requesters valid → req_ready=0 and outputs stable. On release, the grant continues from ptr with no requester skipped or repeated.
- Overflow: 262143 + 1 → SAT=0 gives res_data=-262144, res_ovf=1. SAT=1 gives res_data=262143, res_ovf=1. For -262144 + -1 with SAT=1 → res_data=-262144, res_ovf=1.
- Pointer skip and mid-operation reset: ptr=2 with only requesters 0 and 3 valid → grant 3, then 0. Assert rst while res_valid=1 → the next cycle shows res_valid=0 and ptr=0.
